// File: rtl/coef_bank_seq.sv
// Loadable coefficient bank: writes land in a shadow copy, commits copy shadow to active
// atomically between sequences, and the sequencer streams one set at one coefficient per clock.
module coef_bank_seq #(
  parameter int WIDTH = 25,
  parameter int FRAC  = 20,
  parameter int NCOEF = 6,
  parameter int NSETS = 2,
  parameter int IDXW  = (NCOEF > 1) ? $clog2(NCOEF) : 1,
  parameter int SETW  = (NSETS > 1) ? $clog2(NSETS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [SETW-1:0]  set_sel,
  output logic [WIDTH-1:0] coef,
  output logic [IDXW-1:0]  coef_idx,
  output logic             coef_valid,
  output logic             coef_last,
  output logic             busy,
  input  logic             wr_en,
  input  logic [SETW-1:0]  wr_set,
  input  logic [IDXW-1:0]  wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             commit,
  output logic             commit_pending
);

  localparam int SHL = (FRAC > 20) ? FRAC - 20 : 0;
  localparam int SHR = (FRAC < 20) ? 20 - FRAC : 0;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  // Default biquad set, written as Q.20 integers and rescaled to FRAC.
  function automatic logic [WIDTH-1:0] def_coef(input int idx);
    logic signed [63:0] v;
    case (idx)
      0:       v = 64'sd1048576;
      1:       v = -64'sd2055209;
      2:       v = 64'sd1007157;
      3:       v = 64'sd209;
      4:       v = 64'sd417;
      5:       v = 64'sd209;
      default: v = 64'sd0;
    endcase
    v = (v <<< SHL) >>> SHR;
    return v[WIDTH-1:0];
  endfunction

  state_t            state_q;
  logic [IDXW-1:0]   cnt_q;
  logic [SETW-1:0]   set_q;
  logic              pend_q;
  logic [WIDTH-1:0]  active_q [NSETS][NCOEF];
  logic [WIDTH-1:0]  shadow_q [NSETS][NCOEF];

  logic start_ok;
  logic wr_ok;
  logic last;
  logic apply;

  assign start_ok = start && (int'(set_sel) < NSETS);
  assign wr_ok    = wr_en && (int'(wr_set) < NSETS) && (int'(wr_idx) < NCOEF);
  assign last     = (state_q == S_RUN) && (cnt_q == IDXW'(NCOEF - 1));
  // Apply only at a sequence boundary so a running sequence never sees mixed sets.
  assign apply    = (pend_q || commit) && ((state_q == S_IDLE) || last);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      set_q   <= '0;
      pend_q  <= 1'b0;
      for (int s = 0; s < NSETS; s++) begin
        for (int i = 0; i < NCOEF; i++) begin
          active_q[s][i] <= def_coef(i);
          shadow_q[s][i] <= def_coef(i);
        end
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            state_q <= S_RUN;
            cnt_q   <= '0;
            set_q   <= set_sel;
          end
        end
        S_RUN: begin
          if (last) begin
            cnt_q <= '0;
            if (start_ok) set_q <= set_sel;
            else          state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + IDXW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase

      if (apply) begin
        pend_q <= 1'b0;
        for (int s = 0; s < NSETS; s++) begin
          for (int i = 0; i < NCOEF; i++) active_q[s][i] <= shadow_q[s][i];
        end
      end else if (commit) begin
        pend_q <= 1'b1;
      end

      // Loaded after the copy loop so a same-edge write waits for the next commit.
      if (wr_ok) shadow_q[wr_set][wr_idx] <= wr_data;
    end
  end

  // busy is the FSM state itself (1 = RUN).
  assign busy           = (state_q == S_RUN);
  assign coef_valid     = busy;
  assign coef_last      = last;
  assign coef_idx       = busy ? cnt_q : '0;
  assign coef           = busy ? active_q[set_q][cnt_q] : '0;
  assign commit_pending = pend_q;

endmodule

// File: tb/tb_coef_bank_seq.sv
// Bench for coef_bank_seq: scenario tasks push expected beats into a queue that is drained
// against the streamed coefficients on every falling edge.
module tb_coef_bank_seq;
  localparam int WIDTH = 25;
  localparam int IDXW  = 3;
  localparam int SETW  = 1;
  localparam int EW    = WIDTH + IDXW + 1;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [SETW-1:0]  set_sel;
  logic [WIDTH-1:0] coef;
  logic [IDXW-1:0]  coef_idx;
  logic             coef_valid;
  logic             coef_last;
  logic             busy;
  logic             wr_en;
  logic [SETW-1:0]  wr_set;
  logic [IDXW-1:0]  wr_idx;
  logic [WIDTH-1:0] wr_data;
  logic             commit;
  logic             commit_pending;

  logic [EW-1:0]    exp_q[$];
  logic [WIDTH-1:0] mdl_active [2][6];
  logic [WIDTH-1:0] mdl_shadow [2][6];
  logic [WIDTH-1:0] dflt [6];
  int pass_cnt;
  int total_cnt;

  coef_bank_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .set_sel(set_sel),
    .coef(coef), .coef_idx(coef_idx), .coef_valid(coef_valid), .coef_last(coef_last),
    .busy(busy), .wr_en(wr_en), .wr_set(wr_set), .wr_idx(wr_idx), .wr_data(wr_data),
    .commit(commit), .commit_pending(commit_pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // One clock: edge, then drain the scoreboard at the falling edge.
  task automatic step();
    logic [EW-1:0] e;
    @(posedge clk);
    @(negedge clk);
    if (coef_valid === 1'b1) begin
      total_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_beat: got coef=%h idx=%0d last=%b, required no beat",
                 coef, coef_idx, coef_last);
      end else begin
        e = exp_q.pop_front();
        if ({coef, coef_idx, coef_last} !== e)
          $display("FAIL beat: got coef=%h idx=%0d last=%b, required coef=%h idx=%0d last=%b",
                   coef, coef_idx, coef_last, e[EW-1:IDXW+1], e[IDXW:1], e[0]);
        else pass_cnt++;
      end
    end
  endtask

  task automatic push_seq(input int s);
    for (int i = 0; i < 6; i++)
      exp_q.push_back({mdl_active[s][i], IDXW'(i), (i == 5)});
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 6; i++) begin
        mdl_active[s][i] = dflt[i];
        mdl_shadow[s][i] = dflt[i];
      end
  endtask

  task automatic model_commit();
    for (int s = 0; s < 2; s++)
      for (int i = 0; i < 6; i++) mdl_active[s][i] = mdl_shadow[s][i];
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 40) begin
      step();
      n++;
    end
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL wait_idle: busy=%b after 40 cycles, required 0", busy);
    else pass_cnt++;
  endtask

  task automatic do_write(input int s, input int i, input logic [WIDTH-1:0] d);
    wr_en = 1'b1; wr_set = SETW'(s); wr_idx = IDXW'(i); wr_data = d;
    if (s < 2 && i < 6) mdl_shadow[s][i] = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic run_seq(input int s);
    start = 1'b1; set_sel = SETW'(s);
    push_seq(s);
    step();
    start = 1'b0;
    wait_idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    total_cnt++;
    if ({coef_valid, busy, coef_last, commit_pending} !== 4'b0000)
      $display("FAIL reset_flags: got valid/busy/last/pend=%b%b%b%b, required 0000",
               coef_valid, busy, coef_last, commit_pending);
    else pass_cnt++;
    total_cnt++;
    if (coef !== '0 || coef_idx !== '0)
      $display("FAIL reset_data: got coef=%h idx=%0d, required 0/0", coef, coef_idx);
    else pass_cnt++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_default_seq();
    int n;
    start = 1'b1; set_sel = 1'b0;
    push_seq(0);
    step();
    start = 1'b0;
    total_cnt++;
    if (busy !== 1'b1 || coef_idx !== 3'd0)
      $display("FAIL start_latency: got busy=%b idx=%0d one cycle after start, required 1/0",
               busy, coef_idx);
    else pass_cnt++;
    n = 1;
    for (int k = 0; k < 20; k++) begin
      step();
      if (busy !== 1'b1) break;
      n++;
    end
    total_cnt++;
    if (n != 6) $display("FAIL busy_len: got %0d busy cycles, required 6", n);
    else pass_cnt++;
  endtask

  task automatic test_shadow_commit_idle();
    do_write(1, 1, 25'h1F00000);
    run_seq(1);
    commit = 1'b1;
    step();
    commit = 1'b0;
    model_commit();
    total_cnt++;
    if (commit_pending !== 1'b0)
      $display("FAIL idle_commit_pending: got %b after idle commit edge, required 0", commit_pending);
    else pass_cnt++;
    run_seq(1);
  endtask

  task automatic test_commit_in_run();
    do_write(0, 4, 25'h0000123);
    start = 1'b1; set_sel = 1'b0;
    push_seq(0);
    step();
    start = 1'b0;
    step();
    step();
    commit = 1'b1;
    step();
    commit = 1'b0;
    for (int k = 3; k <= 5; k++) begin
      total_cnt++;
      if (commit_pending !== 1'b1)
        $display("FAIL run_pending_idx%0d: got %b, required 1", k, commit_pending);
      else pass_cnt++;
      step();
    end
    model_commit();
    total_cnt++;
    if (commit_pending !== 1'b0 || busy !== 1'b0)
      $display("FAIL run_apply: got pend=%b busy=%b after last edge, required 0/0",
               commit_pending, busy);
    else pass_cnt++;
    run_seq(0);
  endtask

  task automatic test_back_to_back();
    start = 1'b1; set_sel = 1'b0;
    push_seq(0);
    step();
    start = 1'b0;
    step();
    step();
    step();
    start = 1'b1; set_sel = 1'b1;
    step();
    start = 1'b0;
    step();
    start = 1'b1; set_sel = 1'b1;
    push_seq(1);
    step();
    start = 1'b0;
    total_cnt++;
    if (coef_valid !== 1'b1 || coef_idx !== 3'd0 || coef_last !== 1'b0)
      $display("FAIL b2b_gap: got valid=%b idx=%0d after last beat, required 1/0",
               coef_valid, coef_idx);
    else pass_cnt++;
    wait_idle();
  endtask

  task automatic test_out_of_range();
    do_write(0, 6, 25'h1555555);
    do_write(1, 7, 25'h0AAAAAA);
    commit = 1'b1;
    step();
    commit = 1'b0;
    model_commit();
    total_cnt++;
    if (busy !== 1'b0 || commit_pending !== 1'b0)
      $display("FAIL oor_state: got busy=%b pend=%b, required 0/0", busy, commit_pending);
    else pass_cnt++;
    run_seq(0);
    run_seq(1);
  endtask

  task automatic test_reset_mid_run();
    do_write(0, 0, 25'h0200000);
    commit = 1'b1;
    step();
    commit = 1'b0;
    model_commit();
    start = 1'b1; set_sel = 1'b0;
    for (int i = 0; i < 4; i++) exp_q.push_back({mdl_active[0][i], IDXW'(i), 1'b0});
    step();
    start = 1'b0;
    commit = 1'b1;
    step();
    commit = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    model_reset();
    total_cnt++;
    if ({coef_valid, busy, coef_last, commit_pending} !== 4'b0000 || coef !== '0 || coef_idx !== '0)
      $display("FAIL midrun_reset: got valid=%b busy=%b last=%b pend=%b coef=%h idx=%0d, required all 0",
               coef_valid, busy, coef_last, commit_pending, coef, coef_idx);
    else pass_cnt++;
    run_seq(0);
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0;
    dflt[0] = 25'h0100000; dflt[1] = 25'h1E0A3D7; dflt[2] = 25'h00F5E35;
    dflt[3] = 25'h00000D1; dflt[4] = 25'h00001A1; dflt[5] = 25'h00000D1;
    model_reset();
    rst_n = 1'b0; start = 1'b0; set_sel = '0; wr_en = 1'b0; wr_set = '0;
    wr_idx = '0; wr_data = '0; commit = 1'b0;
    test_reset();
    test_default_seq();
    test_shadow_commit_idle();
    test_commit_in_run();
    test_back_to_back();
    test_out_of_range();
    test_reset_mid_run();
    repeat (3) step();
    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL drain: %0d beats outstanding, required 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
